// File: rtl/packet_tx.sv
// Byte-serial packet transmitter: 2 header bytes, PAYLOAD_BYTES payload bytes pulled
// from an upstream source, then a CRC-16/CCITT over the payload, through one output register.
module packet_tx #(
    parameter int          PAYLOAD_BYTES = 48,
    parameter logic [15:0] CRC_INIT      = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hdr_in,
    output logic        busy,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_done,
    output logic [3:0]  sent_packet_counter,
    output logic [1:0]  dbg_state
);

    // Handshakes: a byte moves on a clock edge where valid & ready are both high;
    // a source holds valid and data stable until that edge.

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CRC} state_t;

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

    state_t      state;
    logic [7:0]  hdr_lo_q;
    logic [15:0] crc_q;
    logic [7:0]  idx;
    logic [1:0]  phase;
    logic        out_free;
    logic        pl_take;

    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    assign out_free  = !tx_valid || tx_ready;
    assign pl_ready  = (state == S_PAY) && (idx <= LAST_IDX) && out_free;
    assign pl_take   = pl_valid && pl_ready;
    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            hdr_lo_q            <= 8'h00;
            crc_q               <= CRC_INIT;
            idx                 <= 8'h00;
            phase               <= 2'd0;
            busy                <= 1'b0;
            tx_data             <= 8'h00;
            tx_valid            <= 1'b0;
            tx_done             <= 1'b0;
            sent_packet_counter <= 4'h0;
        end else begin
            tx_done <= 1'b0;
            // An accepted byte empties the register unless a new byte is loaded below.
            if (tx_valid && tx_ready) tx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // The first header byte goes straight into the output register.
                        hdr_lo_q <= hdr_in[7:0];
                        crc_q    <= CRC_INIT;
                        busy     <= 1'b1;
                        idx      <= 8'h00;
                        phase    <= 2'd0;
                        tx_data  <= hdr_in[15:8];
                        tx_valid <= 1'b1;
                        state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (out_free) begin
                        tx_data  <= hdr_lo_q;
                        tx_valid <= 1'b1;
                        state    <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (pl_take) begin
                        tx_data  <= pl_data;
                        tx_valid <= 1'b1;
                        crc_q    <= crc_byte(crc_q, pl_data);
                        if (idx == LAST_IDX) begin
                            state <= S_CRC;
                            phase <= 2'd0;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                S_CRC: begin
                    case (phase)
                        2'd0: if (out_free) begin
                            tx_data  <= crc_q[15:8];
                            tx_valid <= 1'b1;
                            phase    <= 2'd1;
                        end
                        2'd1: if (out_free) begin
                            tx_data  <= crc_q[7:0];
                            tx_valid <= 1'b1;
                            phase    <= 2'd2;
                        end
                        2'd2: if (tx_valid && tx_ready) begin
                            tx_done             <= 1'b1;
                            busy                <= 1'b0;
                            sent_packet_counter <= sent_packet_counter + 4'd1;
                            phase               <= 2'd3;
                        end
                        // The tx_done cycle is spent here so a start seen with it is ignored.
                        default: begin
                            phase <= 2'd0;
                            state <= S_IDLE;
                        end
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_tx.sv
// Bench for packet_tx: a 9-byte instance for the known CRC vector and a default
// instance driven by a randomized payload source checked against a packet model.
module tb_packet_tx;

    localparam int PB = 48;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // 9-byte instance
    logic        a_start = 1'b0, a_busy, a_pl_valid = 1'b0, a_pl_ready;
    logic [15:0] a_hdr = 16'h0000;
    logic [7:0]  a_pl_data = 8'h00, a_tx_data;
    logic        a_tx_valid, a_tx_done;
    logic        a_tx_ready = 1'b1;
    logic [3:0]  a_cnt;
    logic [1:0]  a_dbg;

    // default instance
    logic        b_start = 1'b0, b_busy, b_pl_valid, b_pl_ready;
    logic [15:0] b_hdr = 16'h0000;
    logic [7:0]  b_pl_data, b_tx_data;
    logic        b_tx_valid, b_tx_done, b_tx_ready;
    logic [3:0]  b_cnt;
    logic [1:0]  b_dbg;

    packet_tx #(.PAYLOAD_BYTES(9)) dut_a (
        .clock(clk), .reset_n(reset_n), .start(a_start), .hdr_in(a_hdr), .busy(a_busy),
        .pl_data(a_pl_data), .pl_valid(a_pl_valid), .pl_ready(a_pl_ready),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .tx_done(a_tx_done), .sent_packet_counter(a_cnt), .dbg_state(a_dbg)
    );

    packet_tx dut_b (
        .clock(clk), .reset_n(reset_n), .start(b_start), .hdr_in(b_hdr), .busy(b_busy),
        .pl_data(b_pl_data), .pl_valid(b_pl_valid), .pl_ready(b_pl_ready),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .tx_done(b_tx_done), .sent_packet_counter(b_cnt), .dbg_state(b_dbg)
    );

    int total = 0;
    int bad = 0;

    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int  done_cnt = 0;
    int  stall_bad = 0;
    int  bubbles = 0;
    bit  rand_rdy = 1'b0;
    bit  gap_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: header, random payload and a bit-serial CRC-16/CCITT over the payload.
    task automatic queue_pkt(input logic [15:0] hdr);
        logic [7:0]  pay[$];
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < PB; i++) begin
            b = 8'($urandom_range(0, 255));
            pay.push_back(b);
            src_q.push_back(b);
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ b[k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        exp_q.push_back(hdr[15:8]);
        exp_q.push_back(hdr[7:0]);
        foreach (pay[i]) exp_q.push_back(pay[i]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
    endtask

    task automatic pulse_start(input logic [15:0] hdr);
        @(posedge clk); #1;
        b_start = 1'b1;
        b_hdr   = hdr;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_hdr   = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // Payload source and downstream ready driver for the default instance.
    initial begin
        bit take, keep;
        int cyc;
        cyc = 0;
        b_pl_valid = 1'b0;
        b_pl_data  = 8'h00;
        b_tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            take = b_pl_valid && b_pl_ready;
            @(posedge clk); #1;
            if (take && src_q.size() > 0) void'(src_q.pop_front());
            cyc++;
            keep = b_pl_valid && !take;
            b_tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            b_pl_valid = (src_q.size() > 0) && (keep || !gap_mode || (cyc % 5) < 3);
            b_pl_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    // Output monitor: accepted bytes, stall stability, tx_done pulses, bubbles.
    initial begin
        bit         hold_pend;
        logic [7:0] hold_val;
        hold_pend = 1'b0;
        hold_val  = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_pend = 1'b0;
            end else begin
                if (b_tx_valid && b_tx_ready) got_q.push_back(b_tx_data);
                if (hold_pend && (!b_tx_valid || b_tx_data !== hold_val)) stall_bad++;
                hold_pend = b_tx_valid && !b_tx_ready;
                hold_val  = b_tx_data;
                if (b_tx_done) done_cnt++;
                if (b_busy && !b_tx_valid) bubbles++;
            end
        end
    end

    initial begin
        logic [7:0]  a_got[$];
        logic [7:0]  a_exp[13];
        logic [15:0] hl[17];
        logic [15:0] h1, h2;
        int vcnt, first, last, adone, k, d0, n, seen;
        bit hs, saw;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(b_tx_valid), 0);
        chk("rst_tx_data", 32'(b_tx_data), 0);
        chk("rst_busy", 32'(b_busy), 0);
        chk("rst_pl_ready", 32'(b_pl_ready), 0);
        chk("rst_tx_done", 32'(b_tx_done), 0);
        chk("rst_counter", 32'(b_cnt), 0);
        reset_n = 1'b1;

        // ---- 9-byte known vector ----
        a_exp = '{8'hC3, 8'hA1, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                  8'h38, 8'h39, 8'h29, 8'hB1};
        a_pl_valid = 1'b1;
        a_pl_data  = 8'h31;
        k = 0; vcnt = 0; first = -1; last = -1; adone = 0;
        @(posedge clk); #1;
        a_start = 1'b1;
        a_hdr   = 16'hC3A1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_hdr   = 16'h5555;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("vec_latency_valid", 32'(a_tx_valid), 1);
                chk("vec_latency_data", 32'(a_tx_data), 32'h00C3);
            end
            if (a_tx_valid) begin
                a_got.push_back(a_tx_data);
                vcnt++;
                last = c;
                if (first < 0) first = c;
            end
            if (a_tx_done) adone++;
            hs = a_pl_valid && a_pl_ready;
            @(posedge clk); #1;
            if (hs) begin
                k++;
                a_pl_data  = 8'h31 + 8'(k);
                a_pl_valid = (k < 9);
            end
        end
        chk("vec_len", 32'(a_got.size()), 13);
        for (int i = 0; i < 13 && i < a_got.size(); i++)
            chk($sformatf("vec_byte%0d", i), 32'(a_got[i]), 32'(a_exp[i]));
        chk("vec_valid_cycles", 32'(vcnt), 13);
        chk("vec_consecutive", 32'(last - first + 1), 13);
        chk("vec_done_once", 32'(adone), 1);
        chk("vec_counter", 32'(a_cnt), 1);

        // ---- 48 bytes, random ready ----
        rand_rdy = 1'b1;
        d0 = done_cnt;
        queue_pkt(16'h1234);
        pulse_start(16'h1234);
        wait_done(d0 + 1, 2000, "rnd_done_timeout");
        repeat (3) @(negedge clk);
        cmp_stream("rnd");
        chk("rnd_done_once", 32'(done_cnt - d0), 1);
        chk("rnd_stalls_stable", 32'(stall_bad), 0);
        chk("rnd_counter", 32'(b_cnt), 1);
        rand_rdy = 1'b0;

        // ---- gapped payload ----
        gap_mode = 1'b1;
        bubbles = 0;
        d0 = done_cnt;
        queue_pkt(16'hBEEF);
        pulse_start(16'hBEEF);
        wait_done(d0 + 1, 2000, "gap_done_timeout");
        repeat (2) @(negedge clk);
        cmp_stream("gap");
        chk("gap_bubbles_seen", 32'(bubbles > 0), 1);
        chk("gap_counter", 32'(b_cnt), 2);
        gap_mode = 1'b0;

        // ---- start on the tx_done cycle ----
        h1 = 16'($urandom_range(0, 65535));
        h2 = 16'($urandom_range(0, 65535));
        queue_pkt(h1);
        queue_pkt(h2);
        pulse_start(h1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_tx_done && n < 2000);
        chk("sod_done_seen", 32'(b_tx_done), 1);
        b_start = 1'b1;
        b_hdr   = h2;
        @(posedge clk); #1;
        @(negedge clk);
        chk("sod_ignored_busy", 32'(b_busy), 0);
        chk("sod_ignored_valid", 32'(b_tx_valid), 0);
        @(posedge clk); #1;
        b_start = 1'b0;
        @(negedge clk);
        chk("sod_next_valid", 32'(b_tx_valid), 1);
        chk("sod_next_data", 32'(b_tx_data), 32'(h2[15:8]));
        chk("sod_next_busy", 32'(b_busy), 1);
        d0 = done_cnt;
        wait_done(d0 + 1, 2000, "sod_done_timeout");
        repeat (2) @(negedge clk);
        cmp_stream("sod");
        chk("sod_counter", 32'(b_cnt), 4);

        // ---- reset mid-packet ----
        queue_pkt(16'hA5A5);
        pulse_start(16'hA5A5);
        n = 0;
        while (got_q.size() < 20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached_20", 32'(got_q.size() >= 20), 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        d0 = done_cnt;
        chk("mid_tx_valid", 32'(b_tx_valid), 0);
        chk("mid_counter", 32'(b_cnt), 0);
        chk("mid_busy", 32'(b_busy), 0);
        chk("mid_pl_ready", 32'(b_pl_ready), 0);
        src_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_no_done", 32'(done_cnt), 32'(d0));
        got_q.delete();
        exp_q.delete();
        d0 = done_cnt;
        queue_pkt(16'h0F0F);
        pulse_start(16'h0F0F);
        wait_done(d0 + 1, 2000, "mid_done_timeout");
        repeat (2) @(negedge clk);
        cmp_stream("post_rst");
        chk("post_rst_counter", 32'(b_cnt), 1);

        // ---- start held high for 17 packets, counter wrap ----
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        src_q.delete();
        rand_rdy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            hl[i] = 16'($urandom_range(0, 65535));
            queue_pkt(hl[i]);
        end
        @(posedge clk); #1;
        b_start = 1'b1;
        b_hdr   = hl[0];
        seen = 0; n = 0;
        while (seen < 17 && n < 6000) begin
            @(negedge clk);
            n++;
            saw = b_tx_done;
            if (saw) begin
                seen++;
                chk($sformatf("wrap_counter_pkt%0d", seen), 32'(b_cnt), 32'(seen % 16));
            end
            @(posedge clk); #1;
            if (seen >= 17) b_start = 1'b0;
            b_hdr = (saw && seen < 17) ? hl[seen] : 16'($urandom_range(0, 65535));
        end
        chk("wrap_all_done", 32'(seen), 17);
        repeat (4) @(negedge clk);
        chk("wrap_idle_busy", 32'(b_busy), 0);
        cmp_stream("wrap");
        chk("final_stalls_stable", 32'(stall_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
